// File: rtl/cmd_queue_pkg.sv
// Shared parameters and state encoding for the host command queue.
package cmd_queue_pkg;

    localparam int unsigned CMD_W_DEF = 64;
    localparam int unsigned DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        CQ_RESET,
        CQ_RUN,
        CQ_HALTED,
        CQ_FLUSH
    } cq_state_t;

endpackage

// File: rtl/cmd_queue_ram.sv
// Command storage: DEPTH x CMD_W register array.
// Writes are synchronous; reads are asynchronous so the head word is visible without delay.
module cmd_queue_ram
    import cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CMD_W = CMD_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [CMD_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [CMD_W-1:0]         rdata
);

    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_queue.sv
// Host command FIFO feeding the core command processor; holds issue while the core is halted.
// Optional statistics outputs (issued_cnt, high_water) are enabled by defining CMD_QUEUE_STATS_EN.
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CMD_W = CMD_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_valid,
    input  logic [CMD_W-1:0]       host_data,
    output logic                   host_ready,
    input  logic                   flush,
    output logic                   cmd_valid,
    output logic [CMD_W-1:0]       cmd_data,
    input  logic                   cmd_ready,
    input  logic                   halted,
    output logic [$clog2(DEPTH):0] count
`ifdef CMD_QUEUE_STATS_EN
    ,
    output logic [31:0]            issued_cnt,
    output logic [$clog2(DEPTH):0] high_water
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cq_state_t        state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic [CMD_W-1:0] head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    cmd_queue_ram #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (host_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // No full-bypass: a pop in the same cycle does not open a slot for the push.
    assign host_ready = ((state == CQ_RUN) || (state == CQ_HALTED)) && !full && !flush;
    assign cmd_valid  = (state == CQ_RUN) && !halted && !empty;
    assign cmd_data   = empty ? '0 : head;

    assign push = host_valid && host_ready;
    assign pop  = cmd_valid && cmd_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flush wins over any handshake in the same cycle; a pop offered alongside it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CQ_RESET;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            state  <= CQ_FLUSH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                CQ_RESET:                     state <= CQ_RUN;
                CQ_RUN, CQ_HALTED, CQ_FLUSH:  state <= halted ? CQ_HALTED : CQ_RUN;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

`ifdef CMD_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issued_cnt <= '0;
            high_water <= '0;
        end else begin
            if (pop) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
            if (count_nxt > high_water) begin
                high_water <= count_nxt;
            end
        end
    end
`endif

endmodule
